// File: rtl/srambank_pkg.sv
// rtl/srambank_pkg.sv - shared widths and response record for the SRAM bank initiator
package srambank_pkg;

    localparam int SRAM_ADDR_W = 9;
    localparam int SRAM_DATA_W = 36;
    localparam int SRAM_WORDS  = 512;

    typedef struct packed {
        logic [8:0]  addr;
        logic [35:0] data;
    } srambank_rsp_t;

    localparam int RSP_W = $bits(srambank_rsp_t);

endpackage

// File: rtl/srambank_rsp_fifo.sv
// rtl/srambank_rsp_fifo.sv - synchronous response FIFO with occupancy count for credit logic
module srambank_rsp_fifo
    import srambank_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [RSP_W-1:0] push_data,
    input  logic             pop,
    output logic [RSP_W-1:0] head,
    output logic [CNT_W-1:0] count
);

    srambank_rsp_t        mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is cleared on reset so the head reads as zero until the first push
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/srambank_initiator.sv
// rtl/srambank_initiator.sv - registers client requests onto one 512x36 SRAM bank and returns read data
module srambank_initiator
    import srambank_pkg::*;
#(
    parameter int RSP_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [SRAM_ADDR_W-1:0] req_addr,
    input  logic [SRAM_DATA_W-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [SRAM_DATA_W-1:0] rsp_rdata,
    output logic [SRAM_ADDR_W-1:0] rsp_addr,
    output logic [SRAM_ADDR_W-1:0] ADDRESS,
    output logic [SRAM_DATA_W-1:0] wd,
    output logic                   banksel,
    output logic                   read,
    output logic                   write,
    input  logic [SRAM_DATA_W-1:0] dataout
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic                   accept;
    logic                   rd_pend;
    logic [SRAM_ADDR_W-1:0] tag;
    logic [1:0]             inflight;
    logic [CNT_W-1:0]       fifo_count;
    logic [RSP_W-1:0]       fifo_head;
    srambank_rsp_t          push_rsp;
    srambank_rsp_t          head_rsp;

    // Every read holds a FIFO slot from accept until pop, so the bank can never overrun it
    assign inflight  = {1'b0, read} + {1'b0, rd_pend};
    assign req_ready = !reset && ((int'(fifo_count) + int'(inflight)) < RSP_DEPTH);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            ADDRESS <= '0;
            wd      <= '0;
            banksel <= 1'b0;
            read    <= 1'b0;
            write   <= 1'b0;
            rd_pend <= 1'b0;
            tag     <= '0;
        end else begin
            banksel <= accept;
            read    <= accept && !req_write;
            write   <= accept && req_write;
            if (accept) begin
                ADDRESS <= req_addr;
                wd      <= req_wdata;
            end
            rd_pend <= read;
            if (read) begin
                tag <= ADDRESS;
            end
        end
    end

    assign push_rsp = '{addr: tag, data: dataout};

    srambank_rsp_fifo #(
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rd_pend),
        .push_data(push_rsp),
        .pop      (rsp_valid && rsp_ready),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign head_rsp  = fifo_head;
    assign rsp_valid = (fifo_count != '0);
    assign rsp_rdata = head_rsp.data;
    assign rsp_addr  = head_rsp.addr;

endmodule

// File: tb/tb_srambank_initiator.sv
// tb/tb_srambank_initiator.sv - scoreboard bench for srambank_initiator with a behavioural bank
module tb_srambank_initiator;
    import srambank_pkg::*;

    localparam int RSP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [35:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [35:0] rsp_rdata;
    logic [8:0]  rsp_addr;
    logic [8:0]  ADDRESS;
    logic [35:0] wd;
    logic        banksel;
    logic        read;
    logic        write;
    logic [35:0] dataout;

    srambank_initiator #(.RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
        .ADDRESS(ADDRESS), .wd(wd), .banksel(banksel), .read(read), .write(write),
        .dataout(dataout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [35:0] bank_mem [0:511];
    logic [35:0] bank_q;
    logic        glitch_en = 1'b0;
    logic [35:0] glitch = '0;

    always @(posedge clk) begin
        if (banksel) begin
            if (write) bank_mem[ADDRESS] <= wd;
            if (read)  bank_q <= bank_mem[ADDRESS];
        end
    end
    assign dataout = glitch_en ? glitch : bank_q;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_pop = 0;
    int vcount = 0;
    int vfirst = -1;
    int vlast = -1;
    int last_rd_acc = 0;
    int stalls = 0;
    logic [35:0]   shadow [0:511];
    srambank_rsp_t exp_q [$];
    srambank_rsp_t e;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: records accepts into the scoreboard and checks every popped response
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            chk("strobe_excl", {63'd0, read === 1'b1 && write === 1'b1}, 64'd0);
            if (rsp_valid) begin
                vcount++;
                if (vfirst < 0) vfirst = cyc;
                vlast = cyc;
            end
            if (req_valid && req_ready) begin
                n_acc++;
                if (req_write) begin
                    shadow[req_addr] = req_wdata;
                end else begin
                    exp_q.push_back(srambank_rsp_t'{addr: req_addr, data: shadow[req_addr]});
                    last_rd_acc = cyc;
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {55'd0, rsp_addr}, 64'h1_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_addr", {55'd0, rsp_addr}, {55'd0, e.addr});
                    chk("rsp_rdata", {28'd0, rsp_rdata}, {28'd0, e.data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [8:0] a, input logic [35:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        chk("issue_ready", {63'd0, req_ready}, 64'd1);
        tick();
    endtask

    initial begin
        int p;
        logic [63:0] r;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 0);
        chk("rst_strobes", {61'd0, banksel, read, write}, 0);
        chk("rst_address", {55'd0, ADDRESS}, 0);
        chk("rst_wd", {28'd0, wd}, 0);
        chk("rst_rsp_rdata", {28'd0, rsp_rdata}, 0);
        chk("rst_rsp_addr", {55'd0, rsp_addr}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Write then read, with latency
        rsp_ready = 1'b1;
        issue(1'b1, 9'd5, 36'h9_ABCD_1234);
        issue(1'b0, 9'd5, '0);
        req_valid = 1'b0;
        vfirst = -1;
        vcount = 0;
        repeat (6) tick();
        chk("rd_latency", 64'(vfirst - last_rd_acc), 64'd3);
        chk("raw_rsp_count", 64'(vcount), 64'd1);

        // Streaming reads of 0..7
        for (int i = 0; i < 8; i++) issue(1'b1, 9'(i), 36'(i));
        req_valid = 1'b0;
        tick();
        vcount = 0;
        vfirst = -1;
        stalls = 0;
        for (int i = 0; i < 8; i++) issue(1'b0, 9'(i), '0);
        req_valid = 1'b0;
        repeat (8) tick();
        chk("stream_stalls", 64'(stalls), 64'd0);
        chk("stream_count", 64'(vcount), 64'd8);
        chk("stream_span", 64'(vlast - vfirst), 64'd7);

        // Backpressure
        rsp_ready = 1'b0;
        n_acc = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req_addr = 9'(k);
            tick();
        end
        @(negedge clk);
        chk("bp_accepts", 64'(n_acc), 64'd4);
        chk("bp_ready_low", {63'd0, req_ready}, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_pop_cycle", {63'd0, req_ready}, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_pop", {63'd0, req_ready}, 1);
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) tick();
        chk("bp_drained", 64'(exp_q.size()), 0);
        chk("bp_total_accepts", 64'(n_acc), 64'd5);

        // Extreme addresses
        p = n_pop;
        issue(1'b1, 9'd511, 36'hF_FFFF_FFFF);
        issue(1'b1, 9'd0, 36'h0_1234_5678);
        issue(1'b0, 9'd511, '0);
        issue(1'b0, 9'd0, '0);
        req_valid = 1'b0;
        repeat (6) tick();
        chk("extreme_rsp_count", 64'(n_pop - p), 64'd2);

        // Reset with two reads in flight and two in the FIFO
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b0, 9'(i), '0);
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_rsp_valid", {63'd0, rsp_valid}, 0);
        chk("rst_mid_queue", 64'(exp_q.size()), 0);
        rsp_ready = 1'b1;
        vcount = 0;
        repeat (6) tick();
        chk("rst_mid_no_stale", 64'(vcount), 0);
        p = n_pop;
        issue(1'b0, 9'd5, '0);
        req_valid = 1'b0;
        repeat (6) tick();
        chk("rst_mid_readback", 64'(n_pop - p), 64'd1);

        // Idle strobes and ignored dataout activity
        vcount = 0;
        glitch_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r = {$urandom, $urandom};
            glitch = r[35:0];
            @(negedge clk);
            chk("idle_strobes", {61'd0, banksel, read, write}, 0);
            tick();
        end
        glitch_en = 1'b0;
        chk("idle_no_rsp", 64'(vcount), 0);
        p = n_pop;
        issue(1'b0, 9'd511, '0);
        req_valid = 1'b0;
        repeat (6) tick();
        chk("idle_readback", 64'(n_pop - p), 64'd1);

        chk("final_queue_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
